// File: rtl/ninjin_ddr_seq.sv
// Burst sequencer in front of the ninjin AXI image master: splits one DMA command
// into bursts of at most BURST_MAX beats that never cross a BOUNDARY-byte line.
module ninjin_ddr_seq #(
  parameter int BURST_MAX = 256,
  parameter int BOUNDARY  = 4096,
  parameter int TWIDTH    = 24,
  parameter int WORDSIZE  = 30,
  parameter int LSB       = 2,
  parameter int LWIDTH    = $clog2(BURST_MAX) + 1
) (
  input  logic                    clk,
  input  logic                    xrst,
  input  logic                    cmd_start,
  input  logic                    cmd_mode,
  input  logic [WORDSIZE+LSB-1:0] cmd_base,
  input  logic [TWIDTH-1:0]       cmd_total,
  input  logic                    rdone,
  input  logic                    bdone,
  input  logic [3:0]              err,
  output logic                    ddr_req,
  output logic                    ddr_mode,
  output logic [WORDSIZE+LSB-1:0] ddr_base,
  output logic [LWIDTH-1:0]       ddr_len,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic [2:0]              dbg_state
);
  localparam int   AW       = WORDSIZE + LSB;
  localparam int   BW       = $clog2(BOUNDARY);
  localparam int   EW       = BW + 1;
  localparam int   CW0      = (TWIDTH > EW) ? TWIDTH : EW;
  localparam int   CW       = (CW0 > LWIDTH) ? CW0 : LWIDTH;
  localparam logic DDR_READ = 1'b0;

  // Handshake: ddr_req is a one-cycle level per burst; the burst is finished by
  // the completion strobe matching its direction (rdone for read, bdone for write).
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_WAIT, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [TWIDTH-1:0] remain_q, remain_d;
  logic              mode_q, mode_d;
  logic [AW-1:0]     base_q, base_d;
  logic [LWIDTH-1:0] len_q, len_d;
  logic              dmode_q, dmode_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;

  logic [EW-1:0]     line_off;
  logic [EW-1:0]     edge_beats;
  logic [CW-1:0]     len_calc;
  logic              cpl;
  logic              unused_err;

  assign unused_err = ^err[3:1];
  assign line_off   = EW'(addr_q[BW-1:0]);
  assign edge_beats = (EW'(BOUNDARY) - line_off) >> LSB;
  assign cpl        = (mode_q == DDR_READ) ? rdone : bdone;

  always_comb begin
    len_calc = CW'(remain_q);
    if (len_calc > CW'(BURST_MAX))  len_calc = CW'(BURST_MAX);
    if (len_calc > CW'(edge_beats)) len_calc = CW'(edge_beats);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    mode_d   = mode_q;
    base_d   = base_q;
    len_d    = len_q;
    dmode_d  = dmode_q;
    busy_d   = busy_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          addr_d   = cmd_base;
          remain_d = cmd_total;
          mode_d   = cmd_mode;
          busy_d   = 1'b1;
          fault_d  = 1'b0;
          state_d  = (cmd_total == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        base_d  = addr_q;
        len_d   = LWIDTH'(len_calc);
        dmode_d = mode_q;
        state_d = S_REQ;
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        // An error in the same cycle as completion takes the abort path.
        if (err[0]) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else if (cpl) begin
          addr_d   = addr_q + (AW'(len_q) << LSB);
          remain_d = remain_q - TWIDTH'(len_q);
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (err[0]) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = (remain_q != '0) ? S_CALC : S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      mode_q   <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      dmode_q  <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      len_q    <= len_d;
      dmode_q  <= dmode_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign ddr_req   = (state_q == S_REQ);
  assign done      = (state_q == S_DONE);
  assign ddr_mode  = dmode_q;
  assign ddr_base  = base_q;
  assign ddr_len   = len_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ninjin_ddr_seq.sv
// Bench for ninjin_ddr_seq: a burst-list model derived from the command drives an
// expected queue; a negedge monitor checks every issued burst against it.
module tb_ninjin_ddr_seq;
  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_mode = 1'b0;
  logic [31:0] cmd_base = '0;
  logic [23:0] cmd_total = '0;
  logic        rdone = 1'b0;
  logic        bdone = 1'b0;
  logic [3:0]  err = '0;
  logic        ddr_req, ddr_mode, busy, done, fault;
  logic [31:0] ddr_base;
  logic [8:0]  ddr_len;
  logic [2:0]  dbg_state;

  int          total_n = 0;
  int          bad_n = 0;
  logic [40:0] exp_q[$];
  logic [40:0] last_e = '0;
  logic        exp_mode = 1'b0;
  int          req_cnt = 0;
  int          low_run = 100;

  ninjin_ddr_seq dut (
    .clk(clk), .xrst(xrst), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_total(cmd_total), .rdone(rdone), .bdone(bdone),
    .err(err), .ddr_req(ddr_req), .ddr_mode(ddr_mode), .ddr_base(ddr_base),
    .ddr_len(ddr_len), .busy(busy), .done(done), .fault(fault),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Burst list straight from the splitting rules, using byte addresses and beat counts.
  task automatic build_model(input logic [31:0] base, input int total);
    logic [31:0] a;
    int rem, edge_b, len;
    a = base;
    rem = total;
    exp_q.delete();
    while (rem > 0) begin
      edge_b = (4096 - int'(a % 32'd4096)) / 4;
      len = rem;
      if (len > 256) len = 256;
      if (len > edge_b) len = edge_b;
      exp_q.push_back({9'(len), a});
      a = a + 32'(len * 4);
      rem -= len;
    end
  endtask

  always @(negedge clk) begin
    if (!xrst) begin
      low_run = 100;
    end else begin
      if (ddr_req) begin
        req_cnt++;
        chk("req_gap", 64'(low_run >= 2), 64'd1);
        if (exp_q.size() == 0) begin
          total_n++;
          bad_n++;
          $display("FAIL unexpected_req: base 0x%0h len %0d, expected no burst", ddr_base, ddr_len);
        end else begin
          last_e = exp_q.pop_front();
          chk("burst_base", ddr_base, last_e[31:0]);
          chk("burst_len", ddr_len, last_e[40:32]);
          chk("burst_mode", ddr_mode, exp_mode);
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      if (done) chk("done_busy", busy, 1);
    end
  end

  task automatic set_cpl(input logic m, input logic v);
    if (m == 1'b0) rdone = v; else bdone = v;
  endtask

  task automatic set_other(input logic m, input logic v);
    if (m == 1'b0) bdone = v; else rdone = v;
  endtask

  // err_ph: 0 none, 1 error in wait, 2 error in gap, 3 error with completion.
  task automatic run_cmd(input logic m, input logic [31:0] base, input int total,
                         input int err_b, input int err_ph, input bit poke);
    int nb, d;
    bit ok, stop, exp_fault;
    build_model(base, total);
    exp_mode = m;
    nb = exp_q.size();
    req_cnt = 0;
    exp_fault = (err_ph != 0) && (err_b >= 0) && (err_b < nb);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_mode = m; cmd_base = base; cmd_total = 24'(total);
    @(posedge clk); #1;
    cmd_start = 1'b0; cmd_mode = 1'($urandom); cmd_base = $urandom; cmd_total = 24'($urandom);
    @(negedge clk);
    chk("busy_on", busy, 1);
    chk("fault_clr", fault, 0);
    chk("done_at_accept", done, 64'(total == 0));
    stop = 1'b0;
    for (int b = 0; b < nb && !stop; b++) begin
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (ddr_req) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        total_n++; bad_n++;
        $display("FAIL req_timeout: no ddr_req for burst %0d, expected one within 20 cycles", b);
        return;
      end
      @(posedge clk); #1;
      if (poke) begin
        cmd_start = 1'b1; cmd_base = 32'h0000_0100; cmd_total = 24'd5;
        @(posedge clk); #1;
        cmd_start = 1'b0;
      end
      d = $urandom_range(0, 3);
      repeat (d) begin
        set_other(m, 1'($urandom));
        @(posedge clk); #1;
      end
      set_other(m, 1'b0);
      chk("hold_base", ddr_base, last_e[31:0]);
      chk("hold_len", ddr_len, last_e[40:32]);
      if (b == err_b && (err_ph == 1 || err_ph == 3)) begin
        err = 4'b0101;
        if (err_ph == 3) set_cpl(m, 1'b1);
        @(posedge clk); #1;
        err = 4'b0000; set_cpl(m, 1'b0);
        @(negedge clk);
        chk("err_done", done, 1);
        stop = 1'b1;
      end else begin
        set_cpl(m, 1'b1);
        @(posedge clk); #1;
        set_cpl(m, 1'b0);
        if (b == err_b && err_ph == 2) err = 4'b0001;
        @(negedge clk);
        chk("gap_no_done", done, 0);
        chk("gap_no_req", ddr_req, 0);
        @(posedge clk); #1;
        err = 4'b0000;
        @(negedge clk);
        if (b == nb - 1 || (b == err_b && err_ph == 2)) begin
          chk("done_k2", done, 1);
          stop = 1'b1;
        end else begin
          chk("mid_no_done", done, 0);
        end
      end
    end
    chk("fault_end", fault, 64'(exp_fault));
    if (exp_fault) exp_q.delete();
    chk("bursts_left", exp_q.size(), 0);
    chk("req_count", req_cnt, exp_fault ? err_b + 1 : nb);
    @(negedge clk);
    chk("busy_off", busy, 0);
    chk("done_pulse", done, 0);
    chk("fault_hold", fault, 64'(exp_fault));
  endtask

  initial begin
    bit ok;
    int tot, eb, eph, r;
    logic [31:0] base;
    repeat (3) @(negedge clk);
    chk("rst_req", ddr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_base", ddr_base, 0);
    chk("rst_len", ddr_len, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    xrst = 1'b1;

    build_model(32'h0, 16);
    chk("model1_n", exp_q.size(), 1);
    chk("model1_b0", exp_q[0], {9'd16, 32'h0});
    run_cmd(1'b0, 32'h0, 16, -1, 0, 1'b0);

    build_model(32'h0FF0, 10);
    chk("model2_n", exp_q.size(), 2);
    chk("model2_b0", exp_q[0], {9'd4, 32'h0FF0});
    chk("model2_b1", exp_q[1], {9'd6, 32'h1000});
    run_cmd(1'b1, 32'h0FF0, 10, -1, 0, 1'b0);

    build_model(32'h0, 600);
    chk("model3_n", exp_q.size(), 3);
    chk("model3_b0", exp_q[0], {9'd256, 32'h0000});
    chk("model3_b1", exp_q[1], {9'd256, 32'h0400});
    chk("model3_b2", exp_q[2], {9'd88, 32'h0800});
    run_cmd(1'b0, 32'h0, 600, -1, 0, 1'b1);

    run_cmd(1'b0, 32'h100, 0, -1, 0, 1'b0);
    run_cmd(1'b0, 32'h0, 600, 0, 1, 1'b0);
    run_cmd(1'b1, 32'h40, 8, -1, 0, 1'b0);
    run_cmd(1'b1, 32'hFFFF_FFF0, 10, -1, 0, 1'b0);
    run_cmd(1'b0, 32'h0, 600, 1, 3, 1'b0);

    // Asynchronous reset while a write burst is outstanding.
    build_model(32'h400, 300);
    exp_mode = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_mode = 1'b1; cmd_base = 32'h400; cmd_total = 24'd300;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ddr_req) begin ok = 1'b1; break; end
    end
    chk("rst_test_req", ok, 1);
    @(posedge clk); #2;
    xrst = 1'b0;
    #1;
    chk("arst_req", ddr_req, 0);
    chk("arst_mode", ddr_mode, 0);
    chk("arst_base", ddr_base, 0);
    chk("arst_len", ddr_len, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_fault", fault, 0);
    exp_q.delete();
    @(posedge clk); #1;
    xrst = 1'b1;
    run_cmd(1'b0, 32'h0FF8, 20, -1, 0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 3);
      if (r == 3) base = 32'hFFFF_F000 | ($urandom & 32'h0000_0FFC);
      else base = $urandom & 32'h0000_3FFC;
      tot = $urandom_range(0, 700);
      if ($urandom_range(0, 3) == 0) begin
        eb = $urandom_range(0, 2);
        eph = $urandom_range(1, 3);
      end else begin
        eb = -1;
        eph = 0;
      end
      run_cmd(1'($urandom_range(0, 1)), base, tot, eb, eph, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
